// File: rtl/xalu.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage; Busy feeds the stall unit.
// Define XALU_MADD_EN to add the madd/maddu/msub/msubu accumulate operations (ops 9-12).
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  XALUOp_E,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] XALUOut
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef XALU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

    logic signed [63:0] a_ext, b_ext, prod_s;
    logic [63:0]        prod_u, result;
    logic               op_valid, op_is_div;

    // Magnitude divide then fix signs: quotient truncates toward zero, remainder follows dividend.
    function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] un, ud, q, r;
        un = n[31] ? (~n + 32'd1) : n;
        ud = d[31] ? (~d + 32'd1) : d;
        q  = (ud == 32'd0) ? 32'd0 : un / ud;
        r  = (ud == 32'd0) ? 32'd0 : un % ud;
        if (n[31] ^ d[31]) q = ~q + 32'd1;
        if (n[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        q = (d == 32'd0) ? 32'd0 : n / d;
        r = (d == 32'd0) ? 32'd0 : n % d;
        return {r, q};
    endfunction

    always_comb begin
        a_ext     = {{32{A[31]}}, A};
        b_ext     = {{32{B[31]}}, B};
        prod_s    = a_ext * b_ext;
        prod_u    = {32'd0, A} * {32'd0, B};
        op_valid  = 1'b0;
        op_is_div = 1'b0;
        result    = {hi_q, lo_q};
        // Divide by zero keeps the old HI/LO as the shadow so the commit is a no-op.
        case (XALUOp_E)
            OP_MULT:  begin op_valid = 1'b1; result = prod_s; end
            OP_MULTU: begin op_valid = 1'b1; result = prod_u; end
            OP_DIV:   begin
                op_valid = 1'b1; op_is_div = 1'b1;
                if (B != 32'd0) result = sdiv(A, B);
            end
            OP_DIVU:  begin
                op_valid = 1'b1; op_is_div = 1'b1;
                if (B != 32'd0) result = udiv(A, B);
            end
`ifdef XALU_MADD_EN
            OP_MADD:  begin op_valid = 1'b1; result = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin op_valid = 1'b1; result = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin op_valid = 1'b1; result = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin op_valid = 1'b1; result = {hi_q, lo_q} - prod_u; end
`endif
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        case (state_q)
            IDLE: begin
                if (Start && op_valid) begin
                    {sh_hi_d, sh_lo_d} = result;
                    cnt_d   = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = RUN;
                end else if (XALUOp_E == OP_MTHI) begin
                    hi_d = A;
                end else if (XALUOp_E == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && Start && state_q == RUN)
            $display("xalu: Start ignored while unit is running (op %0d)", XALUOp_E);
    end
`endif

    assign Busy    = Start | (cnt_q != '0);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign XALUOut = (XALUOp_E == OP_MFHI) ? hi_q :
                     (XALUOp_E == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_xalu.sv
// Randomized self-checking bench for xalu against a cycle-level behavioural HI/LO model.
module tb_xalu;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  XALUOp_E;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO, XALUOut;

`ifdef XALU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    xalu dut (
        .clk(clk), .reset(reset), .Start(Start), .XALUOp_E(XALUOp_E),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .XALUOut(XALUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending result becomes architectural after N further cycles.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          pend = 1'b0;
    longint      cyc = 0, done_cyc = 0;

    function automatic bit is_valid(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_EN && op >= 4'd9 && op <= 4'd12);
    endfunction

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb, ps;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = sa * sb;
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 32'd0) return acc;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            4'd9:  return acc + ps;
            4'd10: return acc + pu;
            4'd11: return acc - ps;
            4'd12: return acc - pu;
            default: return acc;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0;
        end else begin
            if (pend && cyc == done_cyc) begin
                m_hi = p_hi; m_lo = p_lo; pend = 1'b0;
            end else if (!pend) begin
                if (Start && is_valid(XALUOp_E)) begin
                    {p_hi, p_lo} = model_result(XALUOp_E, A, B, {m_hi, m_lo});
                    pend     = 1'b1;
                    done_cyc = cyc + ((XALUOp_E == 4'd3 || XALUOp_E == 4'd4) ? 10 : 5);
                end else if (XALUOp_E == 4'd7) begin
                    m_hi = A;
                end else if (XALUOp_E == 4'd8) begin
                    m_lo = A;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, Busy}, {31'd0, Start | pend});
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        chk("xaluout", XALUOut, (XALUOp_E == 4'd5) ? m_hi : (XALUOp_E == 4'd6) ? m_lo : 32'd0);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = st; XALUOp_E = op; A = a; B = b;
    endtask

    // Counts Busy cycles from the current one on; inputs return to idle after the first.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!Busy) return;
            n++;
            step();
            drive(1'b0, 4'd0, $urandom, $urandom);
        end
        chk("busy_timeout", {31'd0, Busy}, 32'd0);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(1'b1, op, a, b);
        count_busy(n);
    endtask

    initial begin
        int          nb;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        logic [3:0]  start_ops [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0, 4'd5, 4'd13};

        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b1;
        step();

        run(4'd1, 32'hFFFFFFFD, 32'd5, nb);
        chk("mult_busy_cycles", 32'(nb), 32'd6);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFF1);

        run(4'd4, 32'd7, 32'd2, nb);
        chk("divu_busy_cycles", 32'(nb), 32'd11);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);
        run(4'd3, 32'hFFFFFFF9, 32'd2, nb);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        drive(1'b0, 4'd7, 32'h1234, 32'd0);
        step();
        run(4'd3, 32'd5, 32'd0, nb);
        chk("div0_busy_cycles", 32'(nb), 32'd11);
        chk("div0_hi", HI, 32'h1234);
        chk("div0_lo", LO, 32'hFFFFFFFD);

        run(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
        chk("divovf_lo", LO, 32'h80000000);
        chk("divovf_hi", HI, 32'd0);

        // Reset during the third Busy cycle aborts the multiply.
        drive(1'b1, 4'd1, 32'h10000, 32'h10000);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        reset = 1'b0;
        #2;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_lo", LO, 32'd0);
        step();
        reset = 1'b1;
        repeat (8) step();
        chk("abort_nocommit_hi", HI, 32'd0);
        chk("abort_nocommit_lo", LO, 32'd0);

        drive(1'b0, 4'd8, 32'hAB, 32'd0);
        step();
        drive(1'b0, 4'd6, 32'd0, 32'd0);
        #2;
        chk("mflo_out", XALUOut, 32'hAB);
        step();
        drive(1'b1, 4'd1, 32'd2, 32'd3);
        step();
        drive(1'b1, 4'd4, 32'd100, 32'd7);
        count_busy(nb);
        chk("ignored_start_busy", 32'(nb), 32'd5);
        chk("ignored_start_lo", LO, 32'd6);
        chk("ignored_start_hi", HI, 32'd0);

`ifdef XALU_MADD_EN
        drive(1'b0, 4'd7, 32'd0, 32'd0);
        step();
        drive(1'b0, 4'd8, 32'hFFFFFFFF, 32'd0);
        step();
        run(4'd10, 32'd1, 32'd1, nb);
        chk("maddu_busy_cycles", 32'(nb), 32'd6);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
        run(4'd11, 32'd1, 32'd1, nb);
        chk("msub_hi", HI, 32'd0);
        chk("msub_lo", LO, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 15))
                0:       rb = 32'd0;
                1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2:       rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                op = start_ops[$urandom_range(0, 10)];
                drive(1'b1, op, ra, rb);
            end else begin
                op = 4'($urandom_range(0, 8));
                drive(1'b0, op, ra, rb);
            end
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        drive(1'b0, 4'd0, 32'd0, 32'd0);
        count_busy(nb);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
